// File: rtl/mvm_tile_scheduler_if.sv
// Control/handshake bundle between the tile scheduler, the global buffer,
// the PE array and the PE result consumer.
interface mvm_tile_scheduler_if #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DADDR_WIDTH = 7,
  parameter int ROW_WIDTH   = 9
);
  logic                   start;
  logic                   abort;
  logic                   busy;
  logic                   done;
  logic                   gb_rd_en;
  logic [ADDR_WIDTH-1:0]  gb_rd_weight_addr;
  logic [DADDR_WIDTH-1:0] gb_rd_data_addr;
  logic                   row_jumped;
  logic                   pe_en;
  logic                   pe_clr;
  logic                   pe_last;
  logic                   out_valid;
  logic                   out_ready;
  logic [ROW_WIDTH-1:0]   out_row_base;

  modport master (
    input  start, abort, out_ready,
    output busy, done, gb_rd_en, gb_rd_weight_addr, gb_rd_data_addr,
           row_jumped, pe_en, pe_clr, pe_last, out_valid, out_row_base
  );

  modport slave (
    output start, abort, out_ready,
    input  busy, done, gb_rd_en, gb_rd_weight_addr, gb_rd_data_addr,
           row_jumped, pe_en, pe_clr, pe_last, out_valid, out_row_base
  );
endinterface

// File: rtl/mvm_tile_scheduler.sv
// Tile scheduler: walks a row-major weight matrix NUM_PE rows at a time,
// issues global-buffer reads, aligns PE accumulate controls to the read
// latency and hands each finished row group to the result consumer.
module mvm_tile_scheduler #(
  parameter int ADDR_WIDTH  = 16,
  parameter int DADDR_WIDTH = 7,
  parameter int ROW_WIDTH   = 9,
  parameter int MATRIX_ROWS = 384,
  parameter int MATRIX_COLS = 96,
  parameter int NUM_PE      = 4,
  parameter int RD_LAT      = 1
) (
  input logic                  clk,
  input logic                  rst,
  mvm_tile_scheduler_if.master bus
);
  localparam int GROUPS = MATRIX_ROWS / NUM_PE;
  localparam int CW     = (MATRIX_COLS > 1) ? $clog2(MATRIX_COLS) : 1;
  localparam int GW     = (GROUPS > 1) ? $clog2(GROUPS) : 1;
  localparam int DW     = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

  localparam logic [CW-1:0]         COL_LAST   = CW'(MATRIX_COLS - 1);
  localparam logic [GW-1:0]         GRP_LAST   = GW'(GROUPS - 1);
  localparam logic [DW-1:0]         DRN_LAST   = DW'(RD_LAT - 1);
  localparam logic [ADDR_WIDTH-1:0] GRP_STRIDE = ADDR_WIDTH'(NUM_PE * MATRIX_COLS);
  localparam logic [ROW_WIDTH-1:0]  ROW_STRIDE = ROW_WIDTH'(NUM_PE);

  typedef enum logic [2:0] {IDLE, ISSUE, DRAIN, OUTPUT, DONE} state_t;

  typedef struct packed {
    logic en;
    logic clr;
    logic last;
  } pe_ctl_t;

  state_t                r_state;
  logic [CW-1:0]         r_col;
  logic [GW-1:0]         r_group;
  logic [DW-1:0]         r_dcnt;
  logic [ADDR_WIDTH-1:0] r_wbase;
  logic [ROW_WIDTH-1:0]  r_row_base;
  logic                  r_row_jumped;
  pe_ctl_t [RD_LAT:1]    r_pipe;

  logic    w_issue;
  logic    w_abort;
  pe_ctl_t w_issue_ctl;

  // Issue-side PE controls, to be delayed by the read latency
  always_comb begin
    w_issue          = (r_state == ISSUE);
    w_abort          = bus.abort && (r_state != IDLE);
    w_issue_ctl      = '0;
    w_issue_ctl.en   = w_issue;
    w_issue_ctl.clr  = w_issue && (r_col == '0);
    w_issue_ctl.last = w_issue && (r_col == COL_LAST);
  end

  // Main sequencer: state, column/group counters and row-jump pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_col        <= '0;
      r_group      <= '0;
      r_dcnt       <= '0;
      r_wbase      <= '0;
      r_row_base   <= '0;
      r_row_jumped <= 1'b0;
    end else begin
      r_row_jumped <= 1'b0;
      case (r_state)
        IDLE: begin
          if (bus.start && !bus.abort) begin
            r_state    <= ISSUE;
            r_col      <= '0;
            r_group    <= '0;
            r_wbase    <= '0;
            r_row_base <= '0;
          end
        end
        ISSUE: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (r_col == COL_LAST) begin
            r_state <= DRAIN;
            r_dcnt  <= '0;
          end else begin
            r_col <= r_col + 1'b1;
          end
        end
        DRAIN: begin
          if (bus.abort)                r_state <= IDLE;
          else if (r_dcnt == DRN_LAST)  r_state <= OUTPUT;
          else                          r_dcnt  <= r_dcnt + 1'b1;
        end
        OUTPUT: begin
          if (bus.abort) begin
            r_state <= IDLE;
          end else if (bus.out_ready) begin
            if (r_group == GRP_LAST) begin
              r_state <= DONE;
            end else begin
              r_state      <= ISSUE;
              r_group      <= r_group + 1'b1;
              r_col        <= '0;
              r_wbase      <= r_wbase + GRP_STRIDE;
              r_row_base   <= r_row_base + ROW_STRIDE;
              r_row_jumped <= 1'b1;
            end
          end
        end
        DONE:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  // Read-latency delay line; an abort flushes it so no PE strobes leak out
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pipe <= '0;
    end else if (w_abort) begin
      r_pipe <= '0;
    end else begin
      r_pipe[1] <= w_issue_ctl;
      for (int i = 2; i <= RD_LAT; i++) r_pipe[i] <= r_pipe[i-1];
    end
  end

  // Outputs decoded from registered state only; forced to 0 outside their state
  assign bus.busy              = (r_state != IDLE);
  assign bus.done              = (r_state == DONE);
  assign bus.gb_rd_en          = w_issue;
  assign bus.gb_rd_weight_addr = w_issue ? (r_wbase + ADDR_WIDTH'(r_col)) : '0;
  assign bus.gb_rd_data_addr   = w_issue ? DADDR_WIDTH'(r_col) : '0;
  assign bus.row_jumped        = r_row_jumped;
  assign bus.pe_en             = r_pipe[RD_LAT].en;
  assign bus.pe_clr            = r_pipe[RD_LAT].clr;
  assign bus.pe_last           = r_pipe[RD_LAT].last;
  assign bus.out_valid         = (r_state == OUTPUT);
  assign bus.out_row_base      = (r_state == OUTPUT) ? r_row_base : '0;
endmodule

// File: tb/tb_mvm_tile_scheduler.sv
// Bench for mvm_tile_scheduler: a default-latency instance for the full
// pass, backpressure, abort and reset scenarios, plus an RD_LAT=3 instance
// for PE control alignment.
module tb_mvm_tile_scheduler;
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  mvm_tile_scheduler_if ia ();
  mvm_tile_scheduler_if ib ();

  mvm_tile_scheduler #(.RD_LAT(1)) u_dut_a (.clk(clk), .rst(rst), .bus(ia));
  mvm_tile_scheduler #(.RD_LAT(3)) u_dut_b (.clk(clk), .rst(rst), .bus(ib));

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int c_e0 = 0;

  int rq[$];
  int jq[$];

  int n_rd_a = 0, n_pe_a = 0, n_jmp_a = 0, n_hs_a = 0, n_ov_a = 0, n_done_a = 0;
  int done_rel = 0;
  int b_pe_rel = 0, b_clr_rel = 0, b_last_rel = 0, b_ov_rel = 0, b_pe_cnt = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0d want=%0d", tag, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor / scoreboard consumer for instance A
  always @(negedge clk) begin
    if (!rst) begin
      if (ia.gb_rd_en) n_rd_a++;
      if (ia.pe_en)    n_pe_a++;
      if (ia.out_valid) n_ov_a++;
      if (ia.row_jumped) begin
        n_jmp_a++;
        if (jq.size() == 0) chk("jmp_unexpected", ia.gb_rd_weight_addr, 0);
        else                chk("jmp_addr", ia.gb_rd_weight_addr, jq.pop_front());
      end
      if (ia.out_valid && ia.out_ready) begin
        n_hs_a++;
        if (rq.size() == 0) chk("row_unexpected", ia.out_row_base, 0);
        else                chk("row_base", ia.out_row_base, rq.pop_front());
      end
      if (ia.done) begin
        n_done_a++;
        done_rel = cyc - c_e0 + 1;
      end
    end
  end

  // Alignment monitor for instance B (RD_LAT=3), first group only
  always @(negedge clk) begin
    if (!rst && b_ov_rel == 0) begin
      if (ib.pe_en) b_pe_cnt++;
      if (ib.pe_en && b_pe_rel == 0)                b_pe_rel = cyc - c_e0 + 1;
      if (ib.pe_en && ib.pe_clr && b_clr_rel == 0)  b_clr_rel = cyc - c_e0 + 1;
      if (ib.pe_en && ib.pe_last && b_last_rel == 0) b_last_rel = cyc - c_e0 + 1;
      if (ib.out_valid) b_ov_rel = cyc - c_e0 + 1;
    end
  end

  initial begin
    int got;
    int hold;
    int s_pe, s_ov, s_done;
    ia.start = 0; ia.abort = 0; ia.out_ready = 1;
    ib.start = 0; ib.abort = 0; ib.out_ready = 1;

    // Reset state
    #12;
    chk("rst_busy", ia.busy, 0);
    chk("rst_rd_en", ia.gb_rd_en, 0);
    chk("rst_waddr", ia.gb_rd_weight_addr, 0);
    chk("rst_ovalid", ia.out_valid, 0);
    chk("rst_done", ia.done, 0);
    chk("rst_pe_en", ia.pe_en, 0);
    @(negedge clk); rst = 0;
    repeat (3) @(posedge clk);

    // Full pass on both instances, ready always high
    for (int g = 0; g < 96; g++) rq.push_back(g * 4);
    for (int g = 1; g < 96; g++) jq.push_back(g * 384);
    #1; ia.start = 1; ib.start = 1;
    @(posedge clk); #1;
    c_e0 = cyc;
    ia.start = 0; ib.start = 0;
    for (int i = 0; i < 10000 && n_done_a == 0; i++) begin
      @(posedge clk); #1;
      ia.start = (i == 500);   // start while busy must be ignored
    end
    ia.start = 0;
    chk("full_done_seen", n_done_a, 1);
    chk("full_done_time", done_rel, 9409);
    chk("full_rd_cnt", n_rd_a, 9216);
    chk("full_pe_cnt", n_pe_a, 9216);
    chk("full_jmp_cnt", n_jmp_a, 95);
    chk("full_hs_cnt", n_hs_a, 96);
    chk("full_rq_left", rq.size(), 0);
    chk("full_jq_left", jq.size(), 0);
    repeat (3) @(posedge clk); #1;
    chk("full_done_once", n_done_a, 1);
    chk("full_busy_after", ia.busy, 0);

    chk("b_first_pe", b_pe_rel, 4);
    chk("b_first_clr", b_clr_rel, 4);
    chk("b_last", b_last_rel, 99);
    chk("b_out_valid", b_ov_rel, 100);
    chk("b_pe_per_group", b_pe_cnt, 96);
    ib.abort = 1; @(posedge clk); #1; ib.abort = 0;
    chk("b_abort_busy", ib.busy, 0);

    // Backpressure at group 0, then abort at group 5 col 40
    ia.out_ready = 0;
    for (int g = 0; g < 5; g++) rq.push_back(g * 4);
    for (int g = 1; g < 6; g++) jq.push_back(g * 384);
    ia.start = 1; @(posedge clk); #1; ia.start = 0;
    got = 0;
    for (int i = 0; i < 200 && got == 0; i++) begin
      @(posedge clk); #1; got = ia.out_valid;
    end
    chk("bp_reach_output", got, 1);
    hold = 0;
    for (int i = 0; i < 10; i++) begin
      hold += ia.out_valid;
      chk("bp_row_base", ia.out_row_base, 0);
      chk("bp_rd_en", ia.gb_rd_en, 0);
      @(posedge clk); #1;
    end
    hold += ia.out_valid;
    ia.out_ready = 1;
    @(posedge clk); #1;
    chk("bp_hold_cycles", hold, 11);
    chk("bp_g1_rd_en", ia.gb_rd_en, 1);
    chk("bp_g1_addr", ia.gb_rd_weight_addr, 384);
    chk("bp_g1_jump", ia.row_jumped, 1);
    chk("bp_g1_ovalid", ia.out_valid, 0);

    got = 0;
    for (int i = 0; i < 1000 && got == 0; i++) begin
      got = (ia.gb_rd_en && ia.gb_rd_weight_addr == 16'(5 * 384 + 40)) ? 1 : 0;
      if (got == 0) begin @(posedge clk); #1; end
    end
    chk("ab_reach_g5c40", got, 1);
    ia.abort = 1; @(posedge clk); #1; ia.abort = 0;
    chk("ab_busy", ia.busy, 0);
    chk("ab_rd_en", ia.gb_rd_en, 0);
    s_pe = n_pe_a; s_ov = n_ov_a; s_done = n_done_a;
    repeat (300) @(posedge clk); #1;
    chk("ab_no_pe", n_pe_a - s_pe, 0);
    chk("ab_no_ovalid", n_ov_a - s_ov, 0);
    chk("ab_no_done", n_done_a - s_done, 0);
    chk("ab_rq_left", rq.size(), 0);
    chk("ab_jq_left", jq.size(), 0);

    // Restart after abort issues address 0
    ia.start = 1; @(posedge clk); #1; ia.start = 0;
    chk("rs_rd_en", ia.gb_rd_en, 1);
    chk("rs_waddr", ia.gb_rd_weight_addr, 0);
    chk("rs_daddr", ia.gb_rd_data_addr, 0);
    ia.abort = 1; @(posedge clk); #1; ia.abort = 0;

    // start together with abort in IDLE
    ia.start = 1; ia.abort = 1; @(posedge clk); #1;
    ia.start = 0; ia.abort = 0;
    chk("sa_busy0", ia.busy, 0);
    @(posedge clk); #1;
    chk("sa_busy1", ia.busy, 0);

    // Async reset mid-ISSUE, between edges
    ia.start = 1; @(posedge clk); #1; ia.start = 0;
    repeat (20) @(posedge clk);
    #2 rst = 1;
    #1;
    chk("ar_busy", ia.busy, 0);
    chk("ar_rd_en", ia.gb_rd_en, 0);
    chk("ar_waddr", ia.gb_rd_weight_addr, 0);
    chk("ar_daddr", ia.gb_rd_data_addr, 0);
    @(negedge clk); rst = 0;
    repeat (5) @(posedge clk); #1;
    chk("ar_idle_busy", ia.busy, 0);
    chk("ar_idle_rd_en", ia.gb_rd_en, 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/mvm_tile_scheduler.md
# mvm_tile_scheduler

Sequencer for the LSTM matrix-vector datapath: walks a MATRIX_ROWS x MATRIX_COLS weight matrix stored row-major in the global buffer, NUM_PE rows at a time, and drives global-buffer read addresses and PE accumulate controls. It replaces free-running address generation inside `top` with an explicit start/done/abort interface and a per-row-group output handshake toward the PE result consumer. One instance sits between the global buffer and the PE array.

## Interface
- `ADDR_WIDTH`, 16: weight read address width; MATRIX_ROWS*MATRIX_COLS must be <= 2^ADDR_WIDTH.
- `DADDR_WIDTH`, 7: vector (data) address width.
- `ROW_WIDTH`, 9: width of row index outputs.
- `MATRIX_ROWS`, 384: matrix rows; must be a multiple of NUM_PE.
- `MATRIX_COLS`, 96: matrix columns = vector length.
- `NUM_PE`, 4: rows processed in parallel; PE k receives weight at gb_rd_weight_addr + k*MATRIX_COLS (offset applied by buffer banking).
- `RD_LAT`, 1: global-buffer read latency in cycles, >= 1.

Reset is asynchronous and active-high.
- `clk` in 1: single clock, rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: begin a full matrix pass; sampled only in IDLE.
- `abort` in 1: synchronous cancel; priority over start.
- `busy` out 1: high in every state except IDLE.
- `done` out 1: one-cycle pulse after last group handshake.
- `gb_rd_en` out 1: weight+data read strobe.
- `gb_rd_weight_addr` out ADDR_WIDTH: group*NUM_PE*MATRIX_COLS + col.
- `gb_rd_data_addr` out DADDR_WIDTH: col.
- `row_jumped` out 1: pulse on first issue cycle of groups 1..N-1.
- `pe_en` out 1: PE multiply-accumulate enable (gb_rd_en delayed RD_LAT).
- `pe_clr` out 1: with pe_en on column 0; PE loads product instead of accumulating.
- `pe_last` out 1: with pe_en on column MATRIX_COLS-1.
- `out_valid` out 1: PE results for current group complete.
- `out_ready` in 1: consumer accepts results.
- `out_row_base` out ROW_WIDTH: group*NUM_PE, valid with out_valid.

## Operation
- Groups: G = MATRIX_ROWS/NUM_PE (96 by default). Counters: col 0..MATRIX_COLS-1, group 0..G-1.
- States: IDLE, ISSUE, DRAIN, OUTPUT, DONE.
- IDLE: all outputs 0. start=1 and abort=0 -> ISSUE, col=0, group=0.
- ISSUE: gb_rd_en=1, addresses from current counters; col increments each cycle. At col=MATRIX_COLS-1 -> DRAIN.
- DRAIN: RD_LAT cycles (last pe_en occurs in first DRAIN cycle when RD_LAT=1), then -> OUTPUT.
- OUTPUT: out_valid=1, out_row_base stable, gb_rd_en=0, pe_en=0. Hold until out_ready=1. On handshake: group=G-1 -> DONE; else group++, col=0, -> ISSUE with row_jumped=1 that cycle.
- DONE: done=1 one cycle -> IDLE.
- start while busy ignored. out_ready outside OUTPUT ignored.
- abort=1 in any non-IDLE state -> IDLE next cycle; delay-line contents discarded (no pe_en/pe_clr/pe_last after abort cycle), no out_valid, no done. abort with start in IDLE: stay IDLE.
- All outputs registered or decoded from registered state; no combinational path from out_ready/start to outputs other than state transitions.

## Timing
- Reset (async, immediate): state IDLE, counters 0, delay line cleared, all outputs 0.
- start sampled at edge E0: first gb_rd_en/address 0 in cycle E0+1; first pe_en + pe_clr at E0+1+RD_LAT.
- Per group with out_ready=1: MATRIX_COLS + RD_LAT + 1 cycles (98 default).
- Group g (out_ready=1): ISSUE begins E0+1+98g; out_valid at E0+98(g+1); done at E0+98G+1 = E0+9409.
- Backpressure of k cycles extends each affected group by k; addresses frozen, no reads issued.

## Test plan
- Full pass, defaults, out_ready=1, start at E0 -> 9216 gb_rd_en cycles; row_jumped 95 times with gb_rd_weight_addr = 384, 768, ..., 36480; out_row_base 0,4,...,380 (96 handshakes); done single pulse at E0+9409; busy low after.
- Backpressure: out_ready low 10 cycles at group 0 -> out_valid held 11 cycles, out_row_base=0 stable, gb_rd_en=0; group 1 issue (addr 384, row_jumped) the cycle after handshake.
- Alignment, RD_LAT=3 -> pe_clr with first pe_en at E0+4, pe_last at E0+99, out_valid at E0+100; pe_en count per group = 96.
- Abort at group 5 col 40 -> next cycle IDLE, busy=0, no further pe_en, no out_valid, no done; new start issues address 0.
- Async reset asserted mid-ISSUE between clock edges -> all outputs 0 without a clock edge; after release, IDLE until start.
- start pulsed while busy -> ignored, sequence unchanged; start+abort together in IDLE -> remains IDLE.
